sm_controller: RTL and testbench
================================

Name: sm_controller

Overview:
- Parametrised control unit for the simple RISC datapath: 16-bit instruction register, instruction decoder and multi-cycle control FSM in one block.
- Sits between the top-level CPU wrapper and the register-file/ALU datapath.
- Drives every datapath load, select and write strobe.
- Generalised in data width and register-index width; adds a registered-load guard and a defined handling of undefined opcodes.

Parameters:
- DATA_W, 16: width of the sign-extended immediate outputs (must be >= 16).
- REG_W, 3: width of readnum/writenum. The 3-bit instruction fields are zero-extended; REG_W must be >= 3.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; state and IR forced immediately
- s  in  1  start execution of the instruction held in the IR
- load  in  1  capture in into the IR
- in  in  16  instruction word
- w  out  1  1 when idle in WAIT (ready for s/load)
- readnum  out  REG_W  register-file read index
- writenum  out  REG_W  register-file write index (same as readnum)
- write  out  1  register-file write enable
- loada, loadb, loadc, loads  out  1 each  datapath register enables
- asel  out  1  1 = A operand forced to 0
- bsel  out  1  1 = B operand is sximm5
- vsel  out  2  writeback source: 00 = C, 01 = sximm8, 10/11 reserved (never driven)
- ALUop  out  2  ALU function
- shift  out  2  shifter control
- sximm8  out  DATA_W  sign-extended IR[7:0]
- sximm5  out  DATA_W  sign-extended IR[4:0]

Behaviour:
- IR fields:
  - opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], shift = IR[4:3], Rm = IR[2:0].
  - sximm8 replicates IR[7] into the upper DATA_W-8 bits; sximm5 replicates IR[4] into the upper DATA_W-5 bits.
- IR load rule:
  - IR updates on a clk edge with load=1 only while the state is WAIT; load is ignored in every other state.
  - load and s high in the same WAIT cycle: the new word is captured and the FSM enters DECODE, which decodes the new word.
- nsel is internal: Rn, Rd or Rm selects readnum = writenum = {0, field}.
- ALUop = op, except for MOV Rd,Rm, which forces 00 (ADD with A = 0).
- shift = IR[4:3] in all states.
- Reset:
  - State = WAIT, IR = 0.
  - All strobes (write, loada, loadb, loadc, loads) = 0; asel = bsel = 0; vsel = 00.
  - w = 1 while reset is asserted and afterwards.
- Strobe defaults: every strobe is 0 in any state that does not name it.
- States and transitions:
  - WAIT: w=1. s=1 -> DECODE; otherwise stay.
  - DECODE: no strobes. 110/10 -> WIMM; 110/00 -> GETB; 101/xx with op=11 (MVN) -> GETB; 101/other -> GETA; any other opcode -> WAIT (NOP).
  - WIMM: nsel=Rn, vsel=01, write=1 -> WAIT.
  - GETA: nsel=Rn, loada=1 -> GETB.
  - GETB: nsel=Rm, loadb=1 -> EXEC.
  - EXEC: bsel=0; asel=1 for MOV Rd,Rm and MVN, else 0. CMP (101/01): loads=1 -> WAIT. All others: loadc=1 -> WBACK.
  - WBACK: nsel=Rd, vsel=00, write=1 -> WAIT.
- Latency from the s edge back to w=1:
  - MOV imm: 3 cycles.
  - MOV reg and MVN: 5 cycles.
  - ADD and AND: 6 cycles.
  - CMP: 5 cycles.
  - NOP: 2 cycles.
- s held high continuously: a new instruction starts on each return to WAIT.
- s pulsed while not in WAIT: ignored.
- Reset mid-instruction: returns to WAIT asynchronously; any pending write is abandoned (write=0 at once).

Optional Feature:
- Macro: SM_ILLEGAL_TRAP_EN. Defined:
  - Adds output err (1 bit) and state TRAP.
  - DECODE with an undefined opcode, or opcode 110 with op 01/11 -> TRAP.
  - TRAP: err=1, w=0, all strobes 0; held until reset; err resets to 0.
- Not defined: no err port; undefined encodings behave as the NOP above.

Test Plan:
- Reset pulse mid-GETB -> state WAIT immediately, w=1, loadb=0, IR=0x0000.
- IR=0xD105 (MOV R1,#5), s -> after 2 cycles WIMM: writenum=1, vsel=01, write=1, sximm8=0x0005; w=1 on the 3rd edge.
- IR=0xD2F0 (MOV R2,#-16) -> sximm8=0xFFF0 (DATA_W=16); with DATA_W=32, sximm8=0xFFFFFFF0.
- IR=0xA148 (ADD R2,R1,R0,LSL#1) -> GETA readnum=1/loada; GETB readnum=0/loadb; EXEC loadc, ALUop=00, shift=01; WBACK writenum=2, write=1; w returns after 6 cycles.
- IR=0xA900 (CMP R1,R0) -> EXEC with loads=1, loadc=0; no write pulse; back to WAIT after 5 cycles.
- load=1 with in=0xFFFF during EXEC -> IR unchanged. load and s together in WAIT with in=0xD307 -> WIMM writes R3 with 0x0007.

Source files
------------

// File: rtl/sm_controller.sv
// sm_controller: instruction register, decoder and multi-cycle control FSM
// for the simple RISC datapath. Every datapath strobe, select and register
// index is registered. The registers are loaded from the next state, so each
// output matches the state the FSM has just entered.
// Optional build macro: SM_ILLEGAL_TRAP_EN adds the err output and a TRAP
// state for undefined encodings. Without it, undefined encodings act as NOPs.
module sm_controller #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic              w,
    output logic [REG_W-1:0]  readnum,
    output logic [REG_W-1:0]  writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        vsel,
    output logic [1:0]        ALUop,
    output logic [1:0]        shift,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5
`ifdef SM_ILLEGAL_TRAP_EN
    ,
    output logic              err
`endif
);

    localparam int unsigned IR_W  = 16;
    localparam int unsigned FLD_W = 3;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WIMM,
        S_GETA,
        S_GETB,
        S_EXEC,
        S_WBACK,
        S_TRAP
    } state_e;

    state_e            state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;

    logic              w_q, w_d;
    logic              write_q, write_d;
    logic              loada_q, loada_d;
    logic              loadb_q, loadb_d;
    logic              loadc_q, loadc_d;
    logic              loads_q, loads_d;
    logic              asel_q, asel_d;
    logic [1:0]        vsel_q, vsel_d;
    logic [1:0]        aluop_q, aluop_d;
    logic [REG_W-1:0]  rnum_q, rnum_d;
`ifdef SM_ILLEGAL_TRAP_EN
    logic              err_q, err_d;
`endif

    // Fields of the currently held instruction; these steer the DECODE and EXEC transitions.
    logic [2:0]        opc_q;
    logic [1:0]        op_q;
    assign opc_q = ir_q[15:13];
    assign op_q  = ir_q[12:11];

    // Fields of the instruction that will be held after this edge; these drive the look-ahead outputs.
    logic [2:0]        opc_n;
    logic [1:0]        op_n;
    logic [FLD_W-1:0]  rn_n, rd_n, rm_n;
    logic              mov_reg_n, mvn_n, cmp_n;
    assign opc_n     = ir_d[15:13];
    assign op_n      = ir_d[12:11];
    assign rn_n      = ir_d[10:8];
    assign rd_n      = ir_d[7:5];
    assign rm_n      = ir_d[2:0];
    assign mov_reg_n = (opc_n == OPC_MOV) && (op_n == 2'b00);
    assign mvn_n     = (opc_n == OPC_ALU) && (op_n == 2'b11);
    assign cmp_n     = (opc_n == OPC_ALU) && (op_n == 2'b01);

    // Next state, IR capture and look-ahead output decode.
    always_comb begin
        ir_d    = ir_q;
        state_d = state_q;
        w_d     = 1'b0;
        write_d = 1'b0;
        loada_d = 1'b0;
        loadb_d = 1'b0;
        loadc_d = 1'b0;
        loads_d = 1'b0;
        asel_d  = 1'b0;
        vsel_d  = 2'b00;
        rnum_d  = REG_W'(rn_n);
        aluop_d = mov_reg_n ? 2'b00 : op_n;
`ifdef SM_ILLEGAL_TRAP_EN
        err_d   = 1'b0;
`endif

        // The IR accepts a new word only while the FSM is idle.
        if ((state_q == S_WAIT) && load) begin
            ir_d = in;
        end

        case (state_q)
            S_WAIT:   if (s) state_d = S_DECODE;
            S_DECODE: begin
                if ((opc_q == OPC_MOV) && (op_q == 2'b10)) begin
                    state_d = S_WIMM;
                end else if ((opc_q == OPC_MOV) && (op_q == 2'b00)) begin
                    state_d = S_GETB;
                end else if ((opc_q == OPC_ALU) && (op_q == 2'b11)) begin
                    state_d = S_GETB;
                end else if (opc_q == OPC_ALU) begin
                    state_d = S_GETA;
                end else begin
`ifdef SM_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_WIMM:   state_d = S_WAIT;
            S_GETA:   state_d = S_GETB;
            S_GETB:   state_d = S_EXEC;
            S_EXEC:   state_d = ((opc_q == OPC_ALU) && (op_q == 2'b01)) ? S_WAIT : S_WBACK;
            S_WBACK:  state_d = S_WAIT;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_WAIT;
        endcase

        case (state_d)
            S_WAIT:  w_d = 1'b1;
            S_WIMM: begin
                rnum_d  = REG_W'(rn_n);
                vsel_d  = 2'b01;
                write_d = 1'b1;
            end
            S_GETA: begin
                rnum_d  = REG_W'(rn_n);
                loada_d = 1'b1;
            end
            S_GETB: begin
                rnum_d  = REG_W'(rm_n);
                loadb_d = 1'b1;
            end
            S_EXEC: begin
                asel_d = mov_reg_n | mvn_n;
                if (cmp_n) begin
                    loads_d = 1'b1;
                end else begin
                    loadc_d = 1'b1;
                end
            end
            S_WBACK: begin
                rnum_d  = REG_W'(rd_n);
                vsel_d  = 2'b00;
                write_d = 1'b1;
            end
`ifdef SM_ILLEGAL_TRAP_EN
            S_TRAP:  err_d = 1'b1;
`endif
            default: ;
        endcase
    end

    // State, IR and registered control outputs; reset clears them immediately, leaving w high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            w_q     <= 1'b1;
            write_q <= 1'b0;
            loada_q <= 1'b0;
            loadb_q <= 1'b0;
            loadc_q <= 1'b0;
            loads_q <= 1'b0;
            asel_q  <= 1'b0;
            vsel_q  <= 2'b00;
            aluop_q <= 2'b00;
            rnum_q  <= '0;
`ifdef SM_ILLEGAL_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            w_q     <= w_d;
            write_q <= write_d;
            loada_q <= loada_d;
            loadb_q <= loadb_d;
            loadc_q <= loadc_d;
            loads_q <= loads_d;
            asel_q  <= asel_d;
            vsel_q  <= vsel_d;
            aluop_q <= aluop_d;
            rnum_q  <= rnum_d;
`ifdef SM_ILLEGAL_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    assign w        = w_q;
    assign write    = write_q;
    assign loada    = loada_q;
    assign loadb    = loadb_q;
    assign loadc    = loadc_q;
    assign loads    = loads_q;
    assign asel     = asel_q;
    assign bsel     = 1'b0;
    assign vsel     = vsel_q;
    assign ALUop    = aluop_q;
    assign readnum  = rnum_q;
    assign writenum = rnum_q;
    assign shift    = ir_q[4:3];
    assign sximm8   = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
    assign sximm5   = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
`ifdef SM_ILLEGAL_TRAP_EN
    assign err      = err_q;
`endif

endmodule

// File: tb/tb_sm_controller.sv
// Testbench for sm_controller. A reference model expands each instruction into
// the expected per-cycle outputs and pushes them to a scoreboard. Each entry is
// popped and compared after the corresponding clock edge. A second instance
// with DATA_W=32 checks the wide sign extension.
module tb_sm_controller;

    localparam int ST_WAIT  = 0;
    localparam int ST_DEC   = 1;
    localparam int ST_WIMM  = 2;
    localparam int ST_GETA  = 3;
    localparam int ST_GETB  = 4;
    localparam int ST_EXEC  = 5;
    localparam int ST_WBACK = 6;
    localparam int ST_TRAP  = 7;

    logic        clk = 1'b0;
    logic        reset, s, load;
    logic [15:0] in_w;

    logic        w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, aluop, shift;
    logic [15:0] sximm8, sximm5;

    logic        w2, write2, loada2, loadb2, loadc2, loads2, asel2, bsel2;
    logic [2:0]  readnum2, writenum2;
    logic [1:0]  vsel2, aluop2, shift2;
    logic [31:0] sximm8_2, sximm5_2;
`ifdef SM_ILLEGAL_TRAP_EN
    logic        err, err2;
`endif

    sm_controller #(.DATA_W(16), .REG_W(3)) dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in_w),
        .w(w), .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .ALUop(aluop), .shift(shift),
        .sximm8(sximm8), .sximm5(sximm5)
`ifdef SM_ILLEGAL_TRAP_EN
        , .err(err)
`endif
    );

    sm_controller #(.DATA_W(32), .REG_W(3)) dut32 (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in_w),
        .w(w2), .readnum(readnum2), .writenum(writenum2), .write(write2),
        .loada(loada2), .loadb(loadb2), .loadc(loadc2), .loads(loads2),
        .asel(asel2), .bsel(bsel2), .vsel(vsel2), .ALUop(aluop2), .shift(shift2),
        .sximm8(sximm8_2), .sximm5(sximm5_2)
`ifdef SM_ILLEGAL_TRAP_EN
        , .err(err2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [9:0]  ctrl;     // {w, write, loada, loadb, loadc, loads, asel, bsel, vsel}
        logic        rn_chk;
        logic [2:0]  rn;
        logic        ex_chk;
        logic [1:0]  aluop;
        logic [1:0]  sh;
        logic [15:0] imm8;
        logic [31:0] imm8w;
        logic [15:0] imm5;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected outputs for one state of the reference model.
    function automatic exp_t mk(input string tag, input int st, input logic [15:0] ir);
        exp_t e;
        logic mov_reg, mvn, cmp;
        mov_reg  = (ir[15:13] == 3'b110) && (ir[12:11] == 2'b00);
        mvn      = (ir[15:13] == 3'b101) && (ir[12:11] == 2'b11);
        cmp      = (ir[15:13] == 3'b101) && (ir[12:11] == 2'b01);
        e.tag    = tag;
        e.ctrl   = '0;
        e.rn_chk = 1'b0;
        e.rn     = 3'b000;
        e.ex_chk = 1'b0;
        e.aluop  = mov_reg ? 2'b00 : ir[12:11];
        e.sh     = ir[4:3];
        e.imm8   = {{8{ir[7]}}, ir[7:0]};
        e.imm8w  = {{24{ir[7]}}, ir[7:0]};
        e.imm5   = {{11{ir[4]}}, ir[4:0]};
        case (st)
            ST_WAIT:  e.ctrl[9] = 1'b1;
            ST_WIMM:  begin e.ctrl[8] = 1'b1; e.ctrl[1:0] = 2'b01; e.rn_chk = 1'b1; e.rn = ir[10:8]; end
            ST_GETA:  begin e.ctrl[7] = 1'b1; e.rn_chk = 1'b1; e.rn = ir[10:8]; end
            ST_GETB:  begin e.ctrl[6] = 1'b1; e.rn_chk = 1'b1; e.rn = ir[2:0]; end
            ST_EXEC:  begin
                e.ex_chk  = 1'b1;
                e.ctrl[3] = mov_reg | mvn;
                if (cmp) e.ctrl[4] = 1'b1;
                else     e.ctrl[5] = 1'b1;
            end
            ST_WBACK: begin e.ctrl[8] = 1'b1; e.rn_chk = 1'b1; e.rn = ir[7:5]; end
            default:  ;
        endcase
        return e;
    endfunction

    // State reached after edge idx+1 of an instruction started from WAIT.
    function automatic int seq_len(input logic [15:0] ir);
        if (ir[15:13] == 3'b110 && ir[12:11] == 2'b10) return 3;
        if (ir[15:13] == 3'b110 && ir[12:11] == 2'b00) return 5;
        if (ir[15:13] == 3'b101 && ir[12:11] == 2'b00) return 6;
        if (ir[15:13] == 3'b101 && ir[12:11] == 2'b10) return 6;
        if (ir[15:13] == 3'b101) return 5;
        return 2;
    endfunction

    function automatic int st_at(input logic [15:0] ir, input int idx);
        int a[6];
        for (int i = 0; i < 6; i++) a[i] = ST_WAIT;
        a[0] = ST_DEC;
        if (ir[15:13] == 3'b110 && ir[12:11] == 2'b10) begin
            a[1] = ST_WIMM;
        end else if ((ir[15:13] == 3'b110 && ir[12:11] == 2'b00) ||
                     (ir[15:13] == 3'b101 && ir[12:11] == 2'b11)) begin
            a[1] = ST_GETB; a[2] = ST_EXEC; a[3] = ST_WBACK;
        end else if (ir[15:13] == 3'b101 && ir[12:11] == 2'b01) begin
            a[1] = ST_GETA; a[2] = ST_GETB; a[3] = ST_EXEC;
        end else if (ir[15:13] == 3'b101) begin
            a[1] = ST_GETA; a[2] = ST_GETB; a[3] = ST_EXEC; a[4] = ST_WBACK;
        end
        return a[idx];
    endfunction

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".ctrl"}, 32'({w, write, loada, loadb, loadc, loads, asel, bsel, vsel}), 32'(e.ctrl));
        chk({e.tag, ".shift"}, 32'(shift), 32'(e.sh));
        chk({e.tag, ".sximm8"}, 32'(sximm8), 32'(e.imm8));
        chk({e.tag, ".sximm5"}, 32'(sximm5), 32'(e.imm5));
        chk({e.tag, ".sximm8_w32"}, sximm8_2, e.imm8w);
        if (e.rn_chk) begin
            chk({e.tag, ".readnum"}, 32'(readnum), 32'(e.rn));
            chk({e.tag, ".writenum"}, 32'(writenum), 32'(e.rn));
        end
        if (e.ex_chk) chk({e.tag, ".ALUop"}, 32'(aluop), 32'(e.aluop));
    endtask

    // Run one instruction (or reps back-to-back copies). s_mask/ld_mask choose per edge
    // whether s, or a load of 0xFFFF, is driven; combined loads the word together with s.
    task automatic exec(input string tag, input logic [15:0] word, input logic combined,
                        input logic [31:0] s_mask, input logic [31:0] ld_mask, input int reps);
        int len;
        len = seq_len(word);
        if (!combined) begin
            @(negedge clk);
            in_w = word; load = 1'b1; s = 1'b0;
            sb.push_back(mk({tag, ".ld"}, ST_WAIT, word));
            @(posedge clk); #1;
            pop_check();
        end
        for (int e = 0; e < len * reps; e++) begin
            @(negedge clk);
            s    = s_mask[e];
            load = ld_mask[e] || (combined && e == 0);
            in_w = (combined && e == 0) ? word : 16'hFFFF;
            sb.push_back(mk($sformatf("%s.c%0d", tag, e + 1), st_at(word, e % len), word));
            @(posedge clk); #1;
            pop_check();
        end
        @(negedge clk);
        s = 1'b0; load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; s = 1'b0; load = 1'b0; in_w = 16'h0000;
        @(negedge clk);
        sb.push_back(mk("reset_held", ST_WAIT, 16'h0000));
        #1 pop_check();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        sb.push_back(mk("reset_after", ST_WAIT, 16'h0000));
        pop_check();

        exec("mov_imm5",   16'hD105, 1'b0, 32'h1,  32'h0,  1);
        exec("mov_imm_m16", 16'hD2F0, 1'b0, 32'h1,  32'h0,  1);
        exec("add_lsl",    16'hA148, 1'b0, 32'h9,  32'h3E, 1);
        exec("cmp",        16'hA900, 1'b0, 32'h1,  32'h1E, 1);
        exec("mov_reg",    16'hC0E3, 1'b0, 32'h1,  32'h0,  1);
        exec("mvn",        16'hB832, 1'b0, 32'h5,  32'h0,  1);
        exec("and",        16'hB586, 1'b0, 32'h1,  32'h0,  1);
        exec("ld_and_s",   16'hD307, 1'b1, 32'h1,  32'h0,  1);
        exec("s_held",     16'hA148, 1'b0, 32'h41, 32'h0,  2);
`ifndef SM_ILLEGAL_TRAP_EN
        exec("nop_opc0",   16'h0123, 1'b0, 32'h1,  32'h0,  1);
        exec("nop_mov01",  16'hC800, 1'b0, 32'h1,  32'h0,  1);
`endif

        // Reset asserted mid-GETB abandons the instruction and clears the IR at once.
        @(negedge clk);
        in_w = 16'hA148; load = 1'b1;
        sb.push_back(mk("rst_mid.ld", ST_WAIT, 16'hA148));
        @(posedge clk); #1 pop_check();
        @(negedge clk);
        load = 1'b0; s = 1'b1;
        sb.push_back(mk("rst_mid.dec", ST_DEC, 16'hA148));
        @(posedge clk); #1 pop_check();
        @(negedge clk);
        s = 1'b0;
        sb.push_back(mk("rst_mid.geta", ST_GETA, 16'hA148));
        @(posedge clk); #1 pop_check();
        sb.push_back(mk("rst_mid.getb", ST_GETB, 16'hA148));
        @(posedge clk); #1 pop_check();
        #1 reset = 1'b1;
        sb.push_back(mk("rst_mid.async", ST_WAIT, 16'h0000));
        #1 pop_check();
        @(negedge clk);
        reset = 1'b0;

`ifdef SM_ILLEGAL_TRAP_EN
        // An undefined opcode traps until reset.
        @(negedge clk);
        in_w = 16'h0123; load = 1'b1;
        @(negedge clk);
        load = 1'b0; s = 1'b1;
        @(negedge clk);
        s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            sb.push_back(mk($sformatf("trap.c%0d", i), ST_TRAP, 16'h0123));
            pop_check();
            chk($sformatf("trap.err%0d", i), 32'(err), 32'd1);
        end
        #1 reset = 1'b1;
        #1 chk("trap.err_reset", 32'(err), 32'd0);
        chk("trap.w_reset", 32'(w), 32'd1);
        @(negedge clk);
        reset = 1'b0;
`endif

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
